// File: rtl/alu_exec.sv
// alu_exec -- multi-cycle integer execute unit for the RV32I datapath.
//
// Accepts an ALU control code plus two operands through a valid/ready
// handshake, and returns a registered result with a zero flag. Shifts run
// iteratively, one bit position per cycle. Every other operation takes one
// cycle.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   request present
//   in_ready   unit can accept a request this cycle (combinational)
//   alu_ctrl   4-bit operation code
//   op_a       first operand (rs1)
//   op_b       second operand (rs2/imm); op_b[SW-1:0] is the shift amount
//   out_valid  result held and valid
//   out_ready  consumer takes the result this cycle
//   result     registered result
//   zero       result == 0, registered with result
//   illegal    the returned op carried an undefined alu_ctrl code
module alu_exec #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SK_LL = 2'd0,
    SK_RL = 2'd1,
    SK_RA = 2'd2
  } shift_kind_t;

  state_t            state;
  state_t            state_next;
  logic [WIDTH-1:0]  acc;
  logic [WIDTH-1:0]  acc_step;
  logic [SW-1:0]     cnt;
  shift_kind_t       kind;

  logic [WIDTH-1:0]  op_result;
  logic              op_illegal;
  logic              op_is_shift;
  shift_kind_t       op_kind;
  logic [SW-1:0]     shamt;
  logic              start_shift;
  logic              accept;
  logic              shift_last;

  assign in_ready    = (state == IDLE) || (state == DONE && out_ready);
  assign accept      = in_valid && in_ready;
  assign out_valid   = (state == DONE);
  assign shamt       = op_b[SW-1:0];
  assign start_shift = op_is_shift && (shamt != '0);
  assign shift_last  = (state == SHIFT) && (cnt == SW'(1));

  // Single-cycle result. A shift reaching this path has shamt = 0, so its
  // result is op_a unchanged; longer shifts go through the iterative path.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned, which would infer a latch.
    op_result   = '0;
    op_illegal  = 1'b0;
    op_is_shift = 1'b0;
    op_kind     = SK_LL;
    case (alu_ctrl)
      OP_AND: op_result = op_a & op_b;
      OP_OR:  op_result = op_a | op_b;
      OP_ADD: op_result = op_a + op_b;
      OP_XOR: op_result = op_a ^ op_b;
      OP_SUB: op_result = op_a - op_b;
      OP_SLT: op_result = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLL: begin
        op_is_shift = 1'b1;
        op_kind     = SK_LL;
        op_result   = op_a;
      end
      OP_SRL: begin
        op_is_shift = 1'b1;
        op_kind     = SK_RL;
        op_result   = op_a;
      end
      OP_SRA: begin
        op_is_shift = 1'b1;
        op_kind     = SK_RA;
        op_result   = op_a;
      end
      default: op_illegal = 1'b1;
    endcase
  end

  // One bit position of the latched shift kind.
  always_comb begin
    acc_step = acc;
    case (kind)
      SK_LL:   acc_step = {acc[WIDTH-2:0], 1'b0};
      SK_RL:   acc_step = {1'b0, acc[WIDTH-1:1]};
      default: acc_step = {acc[WIDTH-1], acc[WIDTH-1:1]};
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic. IDLE and DONE share the accept path, which gives
  // back-to-back acceptance when DONE is drained on the same edge.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (accept)                         state_next = start_shift ? SHIFT : DONE;
        else if (state == DONE && out_ready) state_next = IDLE;
      end
      SHIFT:   if (shift_last) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath. result/zero/illegal only move when an op completes, so they
  // stay bit-stable in DONE under backpressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      cnt     <= '0;
      kind    <= SK_LL;
      result  <= '0;
      zero    <= 1'b0;
      illegal <= 1'b0;
    end else if (accept) begin
      if (start_shift) begin
        acc  <= op_a;
        cnt  <= shamt;
        kind <= op_kind;
      end else begin
        result  <= op_result;
        zero    <= (op_result == '0);
        illegal <= op_illegal;
      end
    end else if (state == SHIFT) begin
      acc <= acc_step;
      cnt <= cnt - SW'(1);
      if (shift_last) begin
        result  <= acc_step;
        zero    <= (acc_step == '0);
        illegal <= 1'b0;
      end
    end
  end

endmodule

// File: doc/alu_exec.md
# alu_exec

Multi-cycle integer execute unit for the RV32I datapath. It consumes the 4-bit ALU control code from the ALU control decoder together with the two operands, and returns a registered result plus a zero flag for branch resolution. Operations move through a valid/ready handshake on both sides. Shifts run iteratively, one bit position per cycle; every other operation completes in one cycle.

## Interface
Parameters:
- WIDTH, 32, operand/result width; power of two, ≥ 8. The shift amount field is SW = log2(WIDTH) bits.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation request present.
- in_ready  output  1  unit can accept a request this cycle.
- alu_ctrl  input  4  operation code (see Operation).
- op_a  input  WIDTH  first operand (rs1).
- op_b  input  WIDTH  second operand (rs2/imm); for shifts, op_b[SW-1:0] is the shift amount.
- out_valid  output  1  result held and valid.
- out_ready  input  1  consumer takes the result this cycle.
- result  output  WIDTH  registered result.
- zero  output  1  result == 0, registered with result.
- illegal  output  1  the returned op carried an undefined alu_ctrl code.

## Operation
- Codes:
  - 0000 and
  - 0001 or
  - 0010 add
  - 0100 xor
  - 0101 sll
  - 0110 sub
  - 0111 slt (signed; result 1 or 0)
  - 1001 srl
  - 1101 sra
- Any other code returns result 0 with illegal = 1.
- add/sub wrap modulo 2^WIDTH. No overflow or carry output.
- States and transitions:
  - IDLE: accepting.
  - SHIFT: iterating a shift.
  - DONE: result held.
- Accept occurs on a rising edge where in_valid && in_ready. At accept, alu_ctrl, op_a and op_b are captured.
- From IDLE (or DONE with out_ready), on accept:
  - Non-shift code, or shift with shamt = 0: result computed and loaded; next state DONE.
  - Shift with shamt = n > 0: acc ← op_a, cnt ← n, shift kind latched; next state SHIFT.
- In SHIFT, each edge shifts acc one position and decrements cnt:
  - sll: zero fill on the left shift.
  - srl: zero fill from the MSB side.
  - sra: MSB replicated.
  - On the edge where cnt goes 1→0, acc is written to result; next state DONE.
- DONE: out_valid = 1 and result/zero/illegal are stable.
  - out_ready = 1 with no new accept → IDLE.
  - out_ready = 1 with in_valid = 1 → the new op is accepted on the same edge (back-to-back).
- in_ready = (state == IDLE) || (state == DONE && out_ready). in_ready is 0 throughout SHIFT.
- The zero flag is computed from the final result value, including illegal ops (illegal → zero = 1).
- Operand inputs are ignored whenever no accept occurs.

## Timing
- Reset (asynchronous, any state, including mid-SHIFT): state IDLE, in_ready = 1, out_valid = 0, result = 0, zero = 0, illegal = 0, cnt = 0. An in-flight op is discarded and never produces out_valid.
- Latency (accept edge to out_valid high):
  - Non-shift ops and shamt = 0: 1 cycle.
  - Shift by n > 0: n+1 cycles.
- Throughput:
  - One single-cycle op per cycle when out_ready is held high.
  - Shift by n: one op per n+1 cycles.
- Backpressure: with out_ready low, DONE holds result, zero and illegal bit-stable indefinitely. in_ready stays 0 while out_ready is low.
- out_valid, result, zero and illegal change only on clock edges (or on reset). in_ready is combinational on state and out_ready only.
- Maximum shift, n = WIDTH-1: WIDTH cycles of latency. cnt must hold values up to WIDTH-1 without wrap.

## Test plan
- Reset mid-shift: accept sll op_a=1, op_b=20. Assert reset after 5 cycles. Required: out_valid stays 0, in_ready = 1, result = 0. The next add 2+3 returns 5 after 1 cycle.
- Arithmetic/logic sweep, out_ready = 1, back-to-back accepts:
  - add 0xFFFFFFFF+1 → 0, zero = 1.
  - sub 5−7 → 0xFFFFFFFE.
  - slt −1<1 → 1.
  - xor 0xF0F0^0xFF00 → 0x0FF0.
  - Each returns exactly 1 cycle after its accept, with one op per cycle.
- Shifts:
  - sra 0x80000000 by 31 → 0xFFFFFFFF after 32 cycles.
  - srl 0x80000000 by 31 → 0x00000001.
  - sll 0x1 by 0 → 0x1 after 1 cycle.
  - in_ready = 0 during every SHIFT cycle.
- Backpressure: out_ready low for 10 cycles after an and-op result. Required: result/zero stable and in_ready = 0 until release; on release with in_valid high, the next op is accepted on the same edge.
- Illegal code 1111: result = 0, zero = 1, illegal = 1, latency 1. The following legal op clears illegal.
- Random regression: 10k ops with random out_ready, checked against a reference model. Required: results matched in order, no drops or duplicates, and shift latency = shamt+1.
